// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: one-cycle logic/add/sub/compare, bit-serial shifts, valid/ready on both sides.
// Optional bit-serial unsigned multiply for code 1010 when ALU_ITER_MUL_EN is defined.
module alu_iter_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_ITER_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
`endif
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

`ifdef ALU_ITER_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t            state;
  state_t            next_state;
  state_t            load_state;
  logic              accept;
  logic [3:0]        op;
  logic [XLEN-1:0]   work;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   single_res;
  logic [SHW-1:0]    cnt;
`ifdef ALU_ITER_MUL_EN
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   mul_sum;
`endif

  function automatic logic [XLEN-1:0] single_op(input logic [3:0] code,
                                                input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    case (code)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (x < y)};
      OP_SLL, OP_SRL, OP_SRA: r = x;  // only reached with a zero shift amount
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shift_step(input logic [3:0] code,
                                                 input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    case (code)
      OP_SLL:  r = {x[XLEN-2:0], 1'b0};
      OP_SRL:  r = {1'b0, x[XLEN-1:1]};
      OP_SRA:  r = {x[XLEN-1], x[XLEN-1:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  assign accept     = in_valid && in_ready;
  assign single_res = single_op(alu_ctrl, a, b);
  assign shifted    = shift_step(op, work);
`ifdef ALU_ITER_MUL_EN
  assign mul_sum    = acc + (mplier[0] ? work : {XLEN{1'b0}});
`endif

  // State a newly accepted operation enters
  always_comb begin
    load_state = DONE;
    case (alu_ctrl)
      OP_SLL, OP_SRL, OP_SRA: begin
        if (b[SHW-1:0] != {SHW{1'b0}}) load_state = SHIFT;
        else                           load_state = DONE;
      end
`ifdef ALU_ITER_MUL_EN
      OP_MUL:  load_state = MUL;
`endif
      default: load_state = DONE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = load_state;
        else        next_state = IDLE;
      end
      SHIFT: begin
        if (cnt == CNT_ONE) next_state = DONE;
        else                next_state = SHIFT;
      end
`ifdef ALU_ITER_MUL_EN
      MUL: begin
        if (cnt == CNT_ONE) next_state = DONE;
        else                next_state = MUL;
      end
`endif
      DONE: begin
        if (accept)         next_state = load_state;
        else if (out_ready) next_state = IDLE;
        else                next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      SHIFT: busy = 1'b1;
`ifdef ALU_ITER_MUL_EN
      MUL:   busy = 1'b1;
`endif
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath; MUL loads a zero count so the wrap-around yields exactly XLEN iterations
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= {XLEN{1'b0}};
      zero   <= 1'b1;
      op     <= 4'b0000;
      work   <= {XLEN{1'b0}};
      cnt    <= {SHW{1'b0}};
`ifdef ALU_ITER_MUL_EN
      acc    <= {XLEN{1'b0}};
      mplier <= {XLEN{1'b0}};
`endif
    end else if (accept) begin
      op   <= alu_ctrl;
      work <= a;
      cnt  <= b[SHW-1:0];
`ifdef ALU_ITER_MUL_EN
      acc    <= {XLEN{1'b0}};
      mplier <= b;
      if (alu_ctrl == OP_MUL) cnt <= {SHW{1'b0}};
`endif
      if (load_state == DONE) begin
        result <= single_res;
        zero   <= (single_res == {XLEN{1'b0}});
      end
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        result <= shifted;
        zero   <= (shifted == {XLEN{1'b0}});
      end
`ifdef ALU_ITER_MUL_EN
    end else if (state == MUL) begin
      acc    <= mul_sum;
      work   <= {work[XLEN-2:0], 1'b0};
      mplier <= {1'b0, mplier[XLEN-1:1]};
      cnt    <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        result <= mul_sum;
        zero   <= (mul_sum == {XLEN{1'b0}});
      end
`endif
    end
  end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU that consumes the 4-bit alu_ctrl code from the ALU control decoder, plus two operands.
- Produces a registered result and a zero flag for branch resolution.
- Logic ops and add/sub complete in one cycle. Shifts run iteratively, 1 bit per cycle, to save area.
- Valid/ready handshakes on both sides let the control path stall while a shift is in progress.

Parameters:
- XLEN, 32, operand/result width. Must be a power of 2, at least 8.
- SHW, $clog2(XLEN), shift-amount width; shift amount is b[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and alu_ctrl presented
- in_ready  output  1  block can accept an operation this cycle
- alu_ctrl  input  4  operation code
- a  input  XLEN  operand A
- b  input  XLEN  operand B / shift amount
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result
- zero  output  1  result == 0, registered alongside result
- busy  output  1  iterative operation in progress

Behaviour:
- Operation codes (alu_ctrl):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1001 SLTU, 1000 XOR: single-cycle ops.
  - 0011 SLL, 0100 SRL, 0101 SRA: iterative ops.
  - 1010 MUL (only with the optional feature).
  - Any other code: result 0, treated as single-cycle.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN; no overflow flag. SLT/SLTU return 0 or 1, zero-extended.
- States: IDLE, SHIFT, DONE (plus MUL when the optional feature is compiled in).
- Accept: an operation is accepted when in_valid && in_ready. On accept, a, b[SHW-1:0] and alu_ctrl are latched internally.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back accept is allowed in the same cycle the previous result drains.
- Single-cycle op accepted in cycle N: result, zero and out_valid are asserted at N+1, state goes to DONE.
- Shift accepted with amount s:
  - s==0: behaves as a single-cycle op; result = a at N+1.
  - s>0: enter SHIFT. Each cycle shifts the working register 1 bit and decrements a counter. SRA replicates the sign bit; SRL shifts in 0.
  - When the counter reaches 0, go to DONE with out_valid=1.
  - Latency is s+1 cycles from accept to out_valid.
- DONE: result and zero hold stable while out_valid && !out_ready.
  - On out_ready without a new accept: go to IDLE, out_valid=0.
  - On out_ready with a new accept: load the new op in the same cycle.
- busy = (state==SHIFT or MUL). in_ready=0 while busy.
- Reset values: state IDLE, out_valid 0, result 0, zero 1, busy 0, in_ready 1 from the first cycle after reset.
- Reset mid-operation: abort, discard partial work, no out_valid pulse.
- in_valid while busy is ignored; the upstream stage must hold its request.

Optional Feature:
- Macro: ALU_ITER_MUL_EN.
- Defined:
  - Code 1010 performs an unsigned shift-add multiply over XLEN iterations.
  - Result is the low XLEN bits of the product.
  - Latency is XLEN+1 cycles; busy is high meanwhile; the MUL state exists.
- Undefined:
  - 1010 is an unsupported code: result 0 in one cycle.
  - No MUL state, no multiplier datapath.

Test Plan:
1. Reset, then ADD a=5 b=7 with out_ready=1 -> out_valid one cycle after accept, result=12, zero=0; SUB a=9 b=9 -> result=0, zero=1.
2. SLT a=0xFFFFFFFF b=1 -> 1; SLTU with the same operands -> 0; AND 0xF0F0 with 0x0FF0 -> 0x00F0; code 1111 -> 0.
3. SRA a=0x80000000 b=4 -> busy for 4 cycles, in_ready=0, out_valid at accept+5, result=0xF8000000. SLL a=1 b=31 -> 0x80000000 at accept+32. SRL b=0 -> result=a at accept+1.
4. Backpressure: out_ready=0 for 3 cycles after out_valid -> result stable, no new accept. Then out_ready=1 with in_valid=1 (ADD 1+1) -> new op accepted the same cycle, result=2 on the next cycle.
5. Assert rst during SHIFT (SRL b=20, cycle 5) -> next cycle: state IDLE, out_valid=0, result=0, in_ready=1; no stale result appears.
6. With ALU_ITER_MUL_EN: MUL a=1000 b=1000 -> result=1000000 at accept+33. Without the macro: code 1010 -> result 0 at accept+1.
